// File: rtl/dma_ldst_mem_arb.sv
// dma_ldst_mem_arb: per-lane SRAM arbiter between the stream-0 DMA and the SIMD load/store unit.
// Optional build macro MEM_ARB_STATS_EN adds DMA stall and load/store grant counters.
`default_nettype none

module dma_ldst_mem_arb #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int MEM_RD_LATENCY = 2,
  parameter int RDQ_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dma__memc__write_valid,
  input  logic [ADDR_W-1:0] dma__memc__write_address,
  input  logic [DATA_W-1:0] dma__memc__write_data,
  output logic              memc__dma__write_ready,
  input  logic              dma__memc__read_valid,
  input  logic [ADDR_W-1:0] dma__memc__read_address,
  output logic              memc__dma__read_ready,
  input  logic              dma__memc__read_pause,
  output logic [DATA_W-1:0] memc__dma__read_data,
  output logic              memc__dma__read_data_valid,
  input  logic              ldst__memc__request,
  input  logic              ldst__memc__released,
  output logic              memc__ldst__granted,
  input  logic              ldst__memc__write_valid,
  input  logic [ADDR_W-1:0] ldst__memc__write_address,
  input  logic [DATA_W-1:0] ldst__memc__write_data,
  input  logic              ldst__memc__read_valid,
  input  logic [ADDR_W-1:0] ldst__memc__read_address,
  output logic [DATA_W-1:0] memc__ldst__read_data,
  output logic              memc__ldst__read_data_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_dma_stall_cycles,
  output logic [15:0]       stat_ldst_grants
`endif
);

  typedef enum logic [1:0] {
    DMA_OWN  = 2'd0,
    DRAIN    = 2'd1,
    LDST_OWN = 2'd2
  } state_e;

  localparam int   CNT_W = $clog2(RDQ_DEPTH + 1);
  localparam int   PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;

  state_e                    state_q;
  logic                      granted_q;
  logic                      run_q;
  logic                      rr_q, rr_d;
  logic [CNT_W-1:0]          inflight_q, inflight_d;
  logic [CNT_W-1:0]          fcnt_q, fcnt_d;
  logic [PTR_W-1:0]          wptr_q, wptr_d;
  logic [PTR_W-1:0]          rptr_q, rptr_d;
  logic [MEM_RD_LATENCY-1:0] tag_vld_q, tag_ldst_q;
  logic [DATA_W-1:0]         fifo_mem [RDQ_DEPTH];

  logic dma_own, ldst_own, credit_ok;
  logic dma_wr_acc, dma_rd_acc, ldst_wr, ldst_rd;
  logic rd_issue, rd_is_ldst, ret_dma, ret_ldst, fifo_push, fifo_pop;

  // run_q keeps every handshake low during reset and the first cycle after it.
  assign dma_own   = run_q & (state_q == DMA_OWN);
  assign ldst_own  = run_q & (state_q == LDST_OWN);
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fcnt_q}) < (CNT_W + 1)'(RDQ_DEPTH);

  assign memc__dma__read_ready  = dma_own & credit_ok &
                                  ~(dma__memc__write_valid & (rr_q == RR_WR));
  assign memc__dma__write_ready = dma_own &
                                  ~(dma__memc__read_valid & credit_ok & (rr_q == RR_RD));

  assign dma_wr_acc = dma__memc__write_valid & memc__dma__write_ready;
  assign dma_rd_acc = dma__memc__read_valid & memc__dma__read_ready;
  assign ldst_wr    = ldst_own & ldst__memc__write_valid;
  assign ldst_rd    = ldst_own & ldst__memc__read_valid & ~ldst__memc__write_valid;
  assign rd_issue   = dma_rd_acc | ldst_rd;
  assign rd_is_ldst = ldst_rd;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ldst_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ldst__memc__write_address;
      mem_wdata = ldst__memc__write_data;
    end else if (ldst_rd) begin
      mem_en   = 1'b1;
      mem_addr = ldst__memc__read_address;
    end else if (dma_wr_acc) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = dma__memc__write_address;
      mem_wdata = dma__memc__write_data;
    end else if (dma_rd_acc) begin
      mem_en   = 1'b1;
      mem_addr = dma__memc__read_address;
    end
  end

  assign ret_dma   = tag_vld_q[MEM_RD_LATENCY-1] & ~tag_ldst_q[MEM_RD_LATENCY-1];
  assign ret_ldst  = tag_vld_q[MEM_RD_LATENCY-1] & tag_ldst_q[MEM_RD_LATENCY-1];
  assign fifo_push = ret_dma;
  assign fifo_pop  = (fcnt_q != '0) & ~dma__memc__read_pause;

  assign memc__dma__read_data_valid  = (fcnt_q != '0);
  assign memc__dma__read_data        = memc__dma__read_data_valid ? fifo_mem[rptr_q] : '0;
  assign memc__ldst__read_data_valid = ret_ldst;
  assign memc__ldst__read_data       = ret_ldst ? mem_rdata : '0;
  assign memc__ldst__granted         = granted_q;

  always_comb begin
    rr_d = rr_q;
    if (dma_wr_acc)      rr_d = RR_RD;
    else if (dma_rd_acc) rr_d = RR_WR;

    inflight_d = inflight_q;
    if (dma_rd_acc && !ret_dma)      inflight_d = inflight_q + CNT_W'(1);
    else if (!dma_rd_acc && ret_dma) inflight_d = inflight_q - CNT_W'(1);

    fcnt_d = fcnt_q;
    if (fifo_push && !fifo_pop)      fcnt_d = fcnt_q + CNT_W'(1);
    else if (!fifo_push && fifo_pop) fcnt_d = fcnt_q - CNT_W'(1);

    wptr_d = wptr_q;
    if (fifo_push) wptr_d = (wptr_q == PTR_W'(RDQ_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    rptr_d = rptr_q;
    if (fifo_pop)  rptr_d = (rptr_q == PTR_W'(RDQ_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      run_q      <= 1'b0;
      rr_q       <= RR_WR;
      inflight_q <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tag_vld_q  <= '0;
      tag_ldst_q <= '0;
    end else begin
      run_q      <= 1'b1;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tag_vld_q[0]  <= rd_issue;
      tag_ldst_q[0] <= rd_is_ldst;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_ldst_q[i] <= tag_ldst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wptr_q] <= mem_rdata;
  end

  // Ownership FSM; granted is registered alongside the state.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q   <= DMA_OWN;
      granted_q <= 1'b0;
    end else begin
      case (state_q)
        DMA_OWN: begin
          if (ldst__memc__request) state_q <= DRAIN;
        end
        DRAIN: begin
          if (inflight_q == '0) begin
            state_q   <= LDST_OWN;
            granted_q <= 1'b1;
          end
        end
        LDST_OWN: begin
          if (ldst__memc__released) begin
            state_q   <= DMA_OWN;
            granted_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= DMA_OWN;
          granted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] grants_q;
  logic        stall_now;

  assign stall_now = (dma__memc__write_valid & ~memc__dma__write_ready) |
                     (dma__memc__read_valid & ~memc__dma__read_ready);

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      stall_q  <= '0;
      grants_q <= '0;
    end else begin
      if (stall_now && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if ((state_q == DRAIN) && (inflight_q == '0)) grants_q <= grants_q + 16'd1;
    end
  end

  assign stat_dma_stall_cycles = stall_q;
  assign stat_ldst_grants      = grants_q;
`endif

endmodule

`default_nettype wire
